// File: rtl/pipe_pkg.sv
// pipe_pkg: shared defaults, reset values, entry type and Tnew helper for pipeline stage registers
package pipe_pkg;
  localparam int DATA_W_DEF = 128;
  localparam int TNEW_W_DEF = 2;
  localparam int TNEW_MAX_W = 16;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR = 32'h0;
  typedef struct packed {
    logic [31:0]           pc;
    logic [31:0]           instr;
    logic [DATA_W_DEF-1:0] data;
    logic [TNEW_W_DEF-1:0] tnew;
  } stage_entry_t;
  function automatic logic [TNEW_MAX_W-1:0] tnew_sat_dec(input logic [TNEW_MAX_W-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction
endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: one valid flag plus a {pc, instr, payload} entry with load and clear controls
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int          W      = 130,
  parameter logic [31:0] RST_PC = RESET_PC
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_clr,
  input  logic          i_load,
  input  logic [W+63:0] i_d,
  output logic          o_valid,
  output logic [W+63:0] o_q
);
  logic          r_valid;
  logic [W+63:0] r_q;
  // reset wins, then clear (PC kept, rest becomes a nop bubble), then load
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_q     <= {RST_PC, NOP_INSTR, W'(0)};
    end else if (i_clr) begin
      r_valid <= 1'b0;
      r_q     <= {r_q[W+63 -: 32], NOP_INSTR, W'(0)};
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_q     <= i_d;
    end
  end
  assign o_valid = r_valid;
  assign o_q     = r_q;
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage with optional skid entry, flush and Tnew decrement
module pipe_stage_reg #(
  parameter int          DATA_W   = pipe_pkg::DATA_W_DEF,
  parameter int          TNEW_W   = pipe_pkg::TNEW_W_DEF,
  parameter logic [31:0] RESET_PC = pipe_pkg::RESET_PC,
  parameter int          SKID     = 1,
  parameter int          TNEW_DEC = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_pc,
  input  logic [31:0]       in_instr,
  input  logic [DATA_W-1:0] in_data,
  input  logic [TNEW_W-1:0] in_Tnew,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_pc,
  output logic [31:0]       out_instr,
  output logic [DATA_W-1:0] out_data,
  output logic [TNEW_W-1:0] out_Tnew
);
  import pipe_pkg::*;
  localparam int PW = DATA_W + TNEW_W;
  logic              w_in_fire, w_out_fire, w_in_ready;
  logic              w_main_v, w_main_load, w_main_clr, w_skid_v;
  logic [PW+63:0]    w_in_entry, w_main_q, w_skid_q;
  logic [TNEW_W-1:0] w_tnew_cap;
  assign w_tnew_cap  = (TNEW_DEC != 0) ? TNEW_W'(tnew_sat_dec(TNEW_MAX_W'(in_Tnew))) : in_Tnew;
  assign w_in_entry  = {in_pc, in_instr, in_data, w_tnew_cap};
  assign w_in_ready  = (SKID != 0) ? !w_skid_v : (!w_main_v | out_ready);
  assign w_in_fire   = in_valid & w_in_ready;
  assign w_out_fire  = w_main_v & out_ready;
  assign w_main_load = (!w_main_v | w_out_fire) & (w_skid_v | w_in_fire);
  assign w_main_clr  = flush | (w_out_fire & !w_skid_v & !w_in_fire);
  pipe_slot #(.W(PW), .RST_PC(RESET_PC)) u_main (
    .clk     (clk),
    .reset   (reset),
    .i_clr   (w_main_clr),
    .i_load  (w_main_load),
    .i_d     (w_skid_v ? w_skid_q : w_in_entry),
    .o_valid (w_main_v),
    .o_q     (w_main_q)
  );
  if (SKID != 0) begin : g_skid
    pipe_slot #(.W(PW), .RST_PC(RESET_PC)) u_skid (
      .clk     (clk),
      .reset   (reset),
      .i_clr   (flush | (w_skid_v & w_main_load)),
      .i_load  (w_main_v & !w_out_fire & w_in_fire),
      .i_d     (w_in_entry),
      .o_valid (w_skid_v),
      .o_q     (w_skid_q)
    );
  end else begin : g_no_skid
    assign w_skid_v = 1'b0;
    assign w_skid_q = '0;
  end
  assign in_ready  = w_in_ready;
  assign out_valid = w_main_v;
  assign {out_pc, out_instr, out_data, out_Tnew} = w_main_q;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: scoreboard bench driving a SKID=1 and a SKID=0 stage with shared stimulus
module tb_pipe_stage_reg;
  import pipe_pkg::*;
  localparam int DW = DATA_W_DEF;
  localparam int TW = TNEW_W_DEF;
  logic clk = 0;
  logic reset, flush, in_valid, out_ready;
  logic [31:0] in_pc, in_instr;
  logic [DW-1:0] in_data;
  logic [TW-1:0] in_Tnew;
  logic in_ready [2];
  logic out_valid [2];
  logic [31:0] out_pc [2];
  logic [31:0] out_instr [2];
  logic [DW-1:0] out_data [2];
  logic [TW-1:0] out_Tnew [2];
  int checks = 0;
  int errors = 0;
  logic [TW-1:0] tn [5] = '{2'd2, 2'd2, 2'd3, 2'd1, 2'd0};
  logic [TW-1:0] te [5] = '{2'd1, 2'd1, 2'd2, 2'd0, 2'd0};

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [TW-1:0] t);
    in_valid = v;
    in_pc    = pc;
    in_instr = $urandom | 32'h1;
    in_data  = {$urandom, $urandom, $urandom, $urandom};
    in_Tnew  = t;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  for (genvar k = 0; k < 2; k++) begin : g_dut
    stage_entry_t q[$];
    stage_entry_t held;
    bit hold_chk = 0;
    pipe_stage_reg #(.DATA_W(DW), .TNEW_W(TW), .RESET_PC(32'h0000_3000),
                     .SKID(k == 0 ? 1 : 0), .TNEW_DEC(1)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready[k]),
      .in_pc     (in_pc),
      .in_instr  (in_instr),
      .in_data   (in_data),
      .in_Tnew   (in_Tnew),
      .out_valid (out_valid[k]),
      .out_ready (out_ready),
      .out_pc    (out_pc[k]),
      .out_instr (out_instr[k]),
      .out_data  (out_data[k]),
      .out_Tnew  (out_Tnew[k])
    );
    always @(negedge clk) begin
      stage_entry_t o, e;
      o = {out_pc[k], out_instr[k], out_data[k], out_Tnew[k]};
      if (reset) begin
        q.delete();
        hold_chk = 0;
      end else begin
        if (hold_chk) chk($sformatf("stall_hold%0d", k), {out_valid[k], o}, {1'b1, held});
        hold_chk = 0;
        if (!out_valid[k]) chk($sformatf("bubble_zero%0d", k), {out_instr[k], out_Tnew[k]}, '0);
        if (out_valid[k] && out_ready) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_out%0d actual pc=%0h required none", k, out_pc[k]);
          end else begin
            e = q.pop_front();
            chk($sformatf("out_entry%0d", k), o, e);
          end
        end
        if (flush) q.delete();
        else if (in_valid && in_ready[k]) begin
          e.pc    = in_pc;
          e.instr = in_instr;
          e.data  = in_data;
          e.tnew  = (in_Tnew == 0) ? in_Tnew : in_Tnew - TW'(1);
          q.push_back(e);
        end
        if (out_valid[k] && !out_ready && !flush) begin
          hold_chk = 1;
          held = o;
        end
      end
    end
  end

  initial begin
    reset = 1;
    flush = 0;
    out_ready = 1;
    drive(1, 32'h3004, 2);
    repeat (3) tick;
    reset = 0;
    in_valid = 0;
    for (int k = 0; k < 2; k++) begin
      chk("rst_valid", out_valid[k], 0);
      chk("rst_pc", out_pc[k], 32'h3000);
      chk("rst_instr", out_instr[k], 0);
      chk("rst_tnew", out_Tnew[k], 0);
      chk("rst_ready", in_ready[k], 1);
    end
    for (int i = 0; i < 5; i++) begin
      drive(1, 32'h3000 + 32'(4 * i), tn[i]);
      tick;
      for (int k = 0; k < 2; k++) begin
        chk("stream_valid", out_valid[k], 1);
        chk("stream_pc", out_pc[k], 32'h3000 + 32'(4 * i));
        chk("stream_tnew", out_Tnew[k], te[i]);
      end
    end
    in_valid = 0;
    tick;
    for (int k = 0; k < 2; k++) begin
      chk("stream_end_valid", out_valid[k], 0);
      chk("stream_end_instr", out_instr[k], 0);
    end
    out_ready = 0;
    drive(1, 32'h3000, 2);
    tick;
    chk("skid_ready_a", in_ready[0], 1);
    drive(1, 32'h3004, 2);
    #1;
    chk("s0_ready_stall", in_ready[1], 0);
    tick;
    chk("skid_full_ready", in_ready[0], 0);
    chk("skid_main_pc", out_pc[0], 32'h3000);
    in_valid = 0;
    out_ready = 1;
    tick;
    chk("skid_b_valid", out_valid[0], 1);
    chk("skid_b_pc", out_pc[0], 32'h3004);
    chk("skid_ready_back", in_ready[0], 1);
    tick;
    chk("skid_empty", out_valid[0], 0);
    out_ready = 0;
    drive(1, 32'h3020, 1);
    tick;
    chk("s0_ready_full", in_ready[1], 0);
    out_ready = 1;
    drive(1, 32'h3024, 1);
    #1;
    chk("s0_ready_pass", in_ready[1], 1);
    tick;
    chk("s0_replace_valid", out_valid[1], 1);
    chk("s0_replace_pc", out_pc[1], 32'h3024);
    in_valid = 0;
    tick;
    out_ready = 0;
    drive(1, 32'h3040, 3);
    tick;
    drive(1, 32'h3044, 3);
    tick;
    drive(1, 32'h3048, 3);
    flush = 1;
    tick;
    flush = 0;
    in_valid = 0;
    for (int k = 0; k < 2; k++) begin
      chk("flush_valid", out_valid[k], 0);
      chk("flush_instr", out_instr[k], 0);
      chk("flush_tnew", out_Tnew[k], 0);
      chk("flush_pc_held", out_pc[k], 32'h3040);
      chk("flush_ready", in_ready[k], 1);
    end
    out_ready = 1;
    repeat (3) begin
      tick;
      for (int k = 0; k < 2; k++) chk("flush_no_emit", out_valid[k], 0);
    end
    for (int i = 0; i < 10000; i++) begin
      drive($urandom_range(0, 3) != 0, 32'h0001_0000 + 32'(i), TW'($urandom));
      out_ready = $urandom_range(0, 9) < (i / 1000) % 10 + 1;
      flush = $urandom_range(0, 99) == 0;
      reset = i == 5000;
      tick;
    end
    reset = 0;
    flush = 0;
    in_valid = 0;
    out_ready = 1;
    repeat (4) tick;
    chk("drained0", 256'(g_dut[0].q.size()), 0);
    chk("drained1", 256'(g_dut[1].q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised pipeline stage register for the multi-cycle MIPS datapath; generalises the fixed stage registers (D/E/M/W) into one reusable block.
- Adds a valid/ready handshake, an optional one-entry skid buffer for back-pressure, synchronous flush (bubble insertion) and optional saturating Tnew decrement on capture.
- Sits between any two pipeline stages; carries PC, instruction, an opaque payload bus and Tnew.

Parameters:
DATA_W, 128, width of opaque payload (e.g. rs/rt data, ext, alu_out concatenated)
TNEW_W, 2, width of Tnew field
RESET_PC, 32'h0000_3000, PC value driven after reset
SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready
TNEW_DEC, 1, 1 = captured Tnew = max(in_Tnew-1, 0); 0 = captured unchanged

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
flush  input  1  synchronous; invalidates all held entries
in_valid  input  1  upstream entry valid
in_ready  output  1  block can accept this cycle
in_pc  input  32  upstream PC
in_instr  input  32  upstream instruction
in_data  input  DATA_W  upstream payload
in_Tnew  input  TNEW_W  upstream Tnew
out_valid  output  1  output entry valid
out_ready  input  1  downstream accepts
out_pc  output  32  held PC
out_instr  output  32  held instruction (0 = nop when bubble)
out_data  output  DATA_W  held payload
out_Tnew  output  TNEW_W  held Tnew (0 when bubble)

Behaviour:
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready. All state updates on posedge clk.
- Reset (priority 1): out_valid=0, out_pc=RESET_PC, out_instr=0, out_data=0, out_Tnew=0, skid empty. Any in_fire during reset is discarded. in_ready=1 in the first cycle after reset.
- Flush (priority 2): main and skid invalidated; out_instr/out_data/out_Tnew <= 0; out_pc holds its value. An in_fire in the same cycle is dropped. in_ready=1 the next cycle.
- Captured Tnew = TNEW_DEC ? (in_Tnew==0 ? 0 : in_Tnew-1) : in_Tnew. This is applied on entry to the block (main or skid), never while an entry is held.
- SKID=1:
  - in_ready = !skid_valid (registered, no combinational path from out_ready).
  - Main empty or out_fire: if skid_valid, main <= skid and skid empties; else if in_fire, main <= input (0-cycle bubble-free throughput, latency 1).
  - Main valid, no out_fire, in_fire: skid <= input; in_ready drops next cycle.
  - Simultaneous out_fire and skid_valid: skid drains to main. in_fire cannot occur in that cycle because in_ready=0.
  - Order is preserved at all times; no entry is duplicated or lost except by flush/reset.
- SKID=0:
  - in_ready = !out_valid | out_ready (combinational).
  - in_fire loads main. Without in_fire, out_fire clears out_valid, and instr/data/Tnew are zeroed.
- Stall: out_ready=0 holds all outputs stable, Tnew included.
- Bubble definition: out_valid=0, out_instr=0, out_Tnew=0. Downstream hazard logic may read Tnew without gating on valid.
- Steady streaming with out_ready=1 sustains 1 entry/cycle in both SKID modes.

Decomposition:
- Shared package pipe_pkg:
  - TNEW_W default
  - RESET_PC
  - NOP_INSTR = 32'h0
  - a stage_entry_t struct {pc, instr, data, Tnew}
  - function tnew_sat_dec
- Sub-module pipe_slot: one valid+entry register with load/clear controls. Instantiated as main and (when SKID=1) skid.

Test Plan:
1. Reset with in_valid=1, in_pc=0x3004 -> after reset: out_valid=0, out_pc=0x3000, out_instr=0, out_Tnew=0, in_ready=1; the 0x3004 entry is never emitted.
2. Stream 0x3000..0x300C with in_Tnew=2, out_ready=1, TNEW_DEC=1 -> outputs appear 1 cycle later, one per cycle, each out_Tnew=1; in_Tnew=0 gives out_Tnew=0 (saturation).
3. SKID=1: hold out_ready=0 while sending A(0x3000), B(0x3004) -> main=A, skid=B, in_ready=0 next cycle; raise out_ready -> A then B emitted on consecutive cycles, in_ready back to 1 after B moves to main.
4. Flush while main=A, skid=B and in_fire of C -> next cycle out_valid=0, out_instr=0, out_Tnew=0, out_pc unchanged; A, B, C are never emitted.
5. SKID=0, out_ready=0 with out_valid=1 -> in_ready=0 in the same cycle; out_ready=1 with in_valid=1 -> in_ready=1 and the new entry replaces the old one next cycle.
6. Random valid/ready toggling for 10k cycles (both SKID values) -> scoreboard confirms in-order, lossless, duplicate-free delivery and outputs stable whenever out_valid & !out_ready.
